tpu_tile_sequencer: RTL
=======================

Name: tpu_tile_sequencer

Overview:
- Top-level sequencer for the pre-load/systolic datapath: runs one or more 8x8 tiles back to back.
- Per tile it streams weights and activations from the host into the weight and activation memories using valid/ready handshakes.
- It then drives the load-done, weight pre-load, compensation pre-load and calculate controls for fixed cycle counts.
- Finally it drains the SIZE column results to a downstream consumer under backpressure.

Parameters:
- SIZE, 8, systolic array dimension.
- MEM_SIZE, SIZE*SIZE, entries per memory per tile.
- ADDR_WIDTH, $clog2(MEM_SIZE), memory address width.
- CW_CYCLES, 3, number of pre-load cycles with preload_cweight high.
- CAL_CYCLES, 23, calculate cycles (7 skew + 15 propagate + 1 output).
- TILE_W, 8, width of the tile count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- start  in  1  begin a job; sampled only in IDLE.
- num_tiles  in  TILE_W  tiles in the job; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last tile drains.
- wt_valid  in  1  host weight beat valid.
- wt_ready  out  1  sequencer accepts a weight beat.
- act_valid  in  1  host activation beat valid.
- act_ready  out  1  sequencer accepts an activation beat.
- wt_we  out  1  weight memory write strobe; equals wt_valid & wt_ready.
- wt_addr  out  ADDR_WIDTH  weight memory write address.
- act_we  out  1  activation memory write strobe; equals act_valid & act_ready.
- act_addr  out  ADDR_WIDTH  activation memory write address.
- load_mem_done  out  1  one-cycle pulse: both memories full.
- preload_weight  out  1  weight pre-load window.
- preload_cweight  out  1  compensation weight pre-load window.
- cal  out  1  calculate window.
- out_valid  out  1  result column available.
- out_ready  in  1  consumer accepts a result column.
- out_col  out  $clog2(SIZE)  index of the result column being presented.
- tile_idx  out  TILE_W  index of the current tile, starting at 0.

Behaviour:
- Reset (rst==0 at a rising edge): state IDLE.
  - All outputs 0, including tile_idx, addresses and all counters.
  - Applies from any state, mid-tile included. No partial done pulse.
- States and transitions:
  - IDLE -> LOAD -> PRELOAD -> CAL -> DRAIN -> (LOAD | FIN) -> IDLE.
- IDLE:
  - start==1 with num_tiles!=0: latch num_tiles, tile_idx=0, go to LOAD.
  - start with num_tiles==0 is ignored: no busy, no done.
- LOAD:
  - Weight and activation channels are independent.
  - wt_ready=1 while wt_cnt<MEM_SIZE; wt_addr=wt_cnt, incremented on each wt_we. The activation channel behaves identically with act_cnt.
  - A channel that is full drops its ready to 0 in the cycle after its 64th write.
  - wt_we/act_we and the addresses are combinational from the handshake and counter.
  - Once both counts reach MEM_SIZE, the next cycle enters PRELOAD with load_mem_done=1 for exactly that first PRELOAD cycle.
- PRELOAD:
  - Lasts SIZE cycles with preload_weight=1.
  - preload_cweight=1 for the first CW_CYCLES of those cycles.
- CAL:
  - Lasts CAL_CYCLES cycles with cal=1.
  - preload_weight=0 from the first CAL cycle.
- DRAIN:
  - out_valid=1 and out_col starts at 0.
  - On out_valid&out_ready, out_col increments.
  - out_col must be held stable while out_ready=0.
  - Acceptance of column SIZE-1 ends the tile:
    - if tile_idx+1<num_tiles: tile_idx++, clear counters, go to LOAD.
    - else go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Register discipline:
  - All control outputs are registered, except wt_we, act_we and the addresses, which are combinational from registered state and inputs.
  - preload_weight, preload_cweight, cal and load_mem_done are mutually consistent with state; no overlap between the PRELOAD and CAL windows.
- Ignored and edge events:
  - start while busy is ignored.
  - wt_valid or act_valid outside LOAD is ignored: ready stays 0, no write.
- Cycle budget:
  - Minimum per tile with both channels streaming and out_ready held high: 64 + SIZE + CAL_CYCLES + SIZE = 103 cycles.
  - Add 1 cycle for FIN on the last tile.
- Counter widths: wt_cnt/act_cnt are ADDR_WIDTH+1 bits, so no wrap at 64.

Test Plan:
- Reset check: hold rst=0 for 2 cycles with start=1 -> all outputs 0 and busy=0. Release, pulse start with num_tiles=1 -> busy=1 next cycle, wt_ready=act_ready=1.
- Single tile, full throughput: valid held high, out_ready=1.
  - Addresses 0..63 are written on both channels; load_mem_done is pulsed once.
  - preload_weight is high for 8 cycles and preload_cweight for the first 3 of them.
  - cal is high for 23 cycles; out_col runs 0..7.
  - done is pulsed 103 cycles after the first write.
- Skewed loading: weights stream continuously, activations arrive every 3rd cycle.
  - wt_ready drops after the 64th weight.
  - load_mem_done fires only after activation write 63.
  - No extra writes occur.
- Drain backpressure: out_ready=0 for 5 cycles at out_col=3 -> out_valid stays 1 and out_col stays 3; then columns 4..7 complete normally.
- Multi-tile: num_tiles=3 -> tile_idx steps 0->1->2, three load_mem_done pulses, a single done pulse at the end. start=1 mid-job has no effect.
- Reset mid-operation: rst=0 during CAL of tile 1 -> next cycle IDLE, all outputs 0, no done pulse. A new start with num_tiles=1 completes normally from address 0.

Source files
------------

// File: rtl/tpu_tile_sequencer.sv
// Tile sequencer for the pre-load/systolic datapath: loads weights and activations,
// times the pre-load and calculate windows, then drains SIZE result columns per tile.
module tpu_tile_sequencer #(
  parameter int SIZE       = 8,
  parameter int MEM_SIZE   = SIZE*SIZE,
  parameter int ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int CW_CYCLES  = 3,
  parameter int CAL_CYCLES = 23,
  parameter int TILE_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [TILE_W-1:0]       num_tiles,
  output logic                    busy,
  output logic                    done,
  input  logic                    wt_valid,
  output logic                    wt_ready,
  input  logic                    act_valid,
  output logic                    act_ready,
  output logic                    wt_we,
  output logic [ADDR_WIDTH-1:0]   wt_addr,
  output logic                    act_we,
  output logic [ADDR_WIDTH-1:0]   act_addr,
  output logic                    load_mem_done,
  output logic                    preload_weight,
  output logic                    preload_cweight,
  output logic                    cal,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(SIZE)-1:0] out_col,
  output logic [TILE_W-1:0]       tile_idx
);

  localparam int COL_W = $clog2(SIZE);
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int CYC_W = $clog2(SIZE + CAL_CYCLES);

  localparam logic [CNT_W-1:0]  MEM_FULL     = CNT_W'(MEM_SIZE);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CYC_W-1:0]  CYC_ONE      = CYC_W'(1);
  localparam logic [CYC_W-1:0]  CYC_PRE_LAST = CYC_W'(SIZE - 1);
  localparam logic [CYC_W-1:0]  CYC_CAL_LAST = CYC_W'(CAL_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CYC_CW       = CYC_W'(CW_CYCLES);
  localparam logic [COL_W-1:0]  COL_ONE      = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST     = COL_W'(SIZE - 1);
  localparam logic [TILE_W:0]   TILE_ONE     = (TILE_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PRELOAD, S_CAL, S_DRAIN, S_FIN
  } state_t;

  state_t              state_r, state_s;
  logic [CNT_W-1:0]    wt_cnt_r, wt_cnt_s, act_cnt_r, act_cnt_s;
  logic [CYC_W-1:0]    cyc_r, cyc_s;
  logic [COL_W-1:0]    col_s;
  logic [TILE_W-1:0]   tile_s, tiles_r, tiles_s;
  logic [TILE_W:0]     tile_inc_s;
  logic                busy_s, done_s, wt_ready_s, act_ready_s, lmd_s;
  logic                pw_s, pcw_s, cal_s, out_valid_s;

  assign wt_we      = wt_valid & wt_ready;
  assign act_we     = act_valid & act_ready;
  assign wt_addr    = wt_cnt_r[ADDR_WIDTH-1:0];
  assign act_addr   = act_cnt_r[ADDR_WIDTH-1:0];
  assign tile_inc_s = {1'b0, tile_idx} + TILE_ONE;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_s   = state_r;
    wt_cnt_s  = wt_cnt_r;
    act_cnt_s = act_cnt_r;
    cyc_s     = cyc_r;
    col_s     = out_col;
    tile_s    = tile_idx;
    tiles_s   = tiles_r;
    case (state_r)
      S_IDLE: begin
        if (start && (num_tiles != '0)) begin
          state_s   = S_LOAD;
          tiles_s   = num_tiles;
          tile_s    = '0;
          wt_cnt_s  = '0;
          act_cnt_s = '0;
          col_s     = '0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (wt_we) wt_cnt_s = wt_cnt_r + CNT_ONE;
        else       wt_cnt_s = wt_cnt_r;
        if (act_we) act_cnt_s = act_cnt_r + CNT_ONE;
        else        act_cnt_s = act_cnt_r;
        if ((wt_cnt_s == MEM_FULL) && (act_cnt_s == MEM_FULL)) begin
          state_s = S_PRELOAD;
          cyc_s   = '0;
        end else begin
          state_s = S_LOAD;
        end
      end
      S_PRELOAD: begin
        if (cyc_r == CYC_PRE_LAST) begin
          state_s = S_CAL;
          cyc_s   = '0;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      S_CAL: begin
        if (cyc_r == CYC_CAL_LAST) begin
          state_s = S_DRAIN;
          cyc_s   = '0;
          col_s   = '0;
        end else begin
          cyc_s = cyc_r + CYC_ONE;
        end
      end
      S_DRAIN: begin
        if (out_valid && out_ready) begin
          if (out_col == COL_LAST) begin
            col_s = '0;
            // Another tile follows: restart loading from address 0.
            if (tile_inc_s < {1'b0, tiles_r}) begin
              tile_s    = tile_inc_s[TILE_W-1:0];
              wt_cnt_s  = '0;
              act_cnt_s = '0;
              state_s   = S_LOAD;
            end else begin
              state_s = S_FIN;
            end
          end else begin
            col_s = out_col + COL_ONE;
          end
        end else begin
          col_s = out_col;
        end
      end
      S_FIN:   state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase

    busy_s      = (state_s != S_IDLE);
    done_s      = (state_s == S_FIN);
    wt_ready_s  = (state_s == S_LOAD) && (wt_cnt_s < MEM_FULL);
    act_ready_s = (state_s == S_LOAD) && (act_cnt_s < MEM_FULL);
    lmd_s       = (state_r == S_LOAD) && (state_s == S_PRELOAD);
    pw_s        = (state_s == S_PRELOAD);
    pcw_s       = (state_s == S_PRELOAD) && (cyc_s < CYC_CW);
    cal_s       = (state_s == S_CAL);
    out_valid_s = (state_s == S_DRAIN);
  end

  // State, counters and registered control outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r         <= S_IDLE;
      wt_cnt_r        <= '0;
      act_cnt_r       <= '0;
      cyc_r           <= '0;
      tiles_r         <= '0;
      out_col         <= '0;
      tile_idx        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      wt_ready        <= 1'b0;
      act_ready       <= 1'b0;
      load_mem_done   <= 1'b0;
      preload_weight  <= 1'b0;
      preload_cweight <= 1'b0;
      cal             <= 1'b0;
      out_valid       <= 1'b0;
    end else begin
      state_r         <= state_s;
      wt_cnt_r        <= wt_cnt_s;
      act_cnt_r       <= act_cnt_s;
      cyc_r           <= cyc_s;
      tiles_r         <= tiles_s;
      out_col         <= col_s;
      tile_idx        <= tile_s;
      busy            <= busy_s;
      done            <= done_s;
      wt_ready        <= wt_ready_s;
      act_ready       <= act_ready_s;
      load_mem_done   <= lmd_s;
      preload_weight  <= pw_s;
      preload_cweight <= pcw_s;
      cal             <= cal_s;
      out_valid       <= out_valid_s;
    end
  end

endmodule
